mem_initiator: RTL and testbench

Requester-side controller for the dual-read / single-write register memory in the pipelined CPU. Accepts one command at a time from the pipeline over a valid/ready handshake and drives the memory's write port and both read ports with registered signals. It waits the memory's fixed read latency, then holds captured read data on a valid/ready response channel until the pipeline takes it.

---
 rtl/mem_initiator_if.sv | 47 ++++
 rtl/mem_initiator.sv | 137 +++++++++++++
 tb/tb_mem_initiator.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_if.sv
// Command, response and memory-port bundle between the pipeline, mem_initiator and the register memory.
// master is the initiator's view; slave is the environment (pipeline plus memory) view.
interface mem_initiator_if #(
    parameter int AW = 11,
    parameter int DW = 11
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_adrs_a;
    logic [AW-1:0] cmd_adrs_b;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;
    logic          err_illegal;

    logic          w_en;
    logic [AW-1:0] w_adrs;
    logic [DW-1:0] data_in;
    logic          r_en1;
    logic [AW-1:0] r_adrs1;
    logic          r_en2;
    logic [AW-1:0] r_adrs2;
    logic [DW-1:0] data_out1;
    logic [DW-1:0] data_out2;

    modport master (
        input  cmd_valid, cmd_op, cmd_adrs_a, cmd_adrs_b, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_data1, rsp_data2, err_illegal,
        input  rsp_ready,
        output w_en, w_adrs, data_in, r_en1, r_adrs1, r_en2, r_adrs2,
        input  data_out1, data_out2
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_adrs_a, cmd_adrs_b, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_data1, rsp_data2, err_illegal,
        output rsp_ready,
        input  w_en, w_adrs, data_in, r_en1, r_adrs1, r_en2, r_adrs2,
        output data_out1, data_out2
    );
endinterface

// File: rtl/mem_initiator.sv
// Single-outstanding requester for the dual-read / single-write register memory.
// Memory strobes are registered at the accept edge so they are high for exactly the ISSUE cycle.
module mem_initiator #(
    parameter int AW     = 11,
    parameter int DW     = 11,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            resetn,
    mem_initiator_if.master bus
);
    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ2   = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    op_reg;

    logic          w_en_reg, r_en1_reg, r_en2_reg;
    logic [AW-1:0] w_adrs_reg, r_adrs1_reg, r_adrs2_reg;
    logic [DW-1:0] data_in_reg;
    logic [DW-1:0] rsp_data1_reg, rsp_data2_reg;
    logic          err_reg;

    logic accept;
    logic capture;

    assign accept  = (state_reg == IDLE) && bus.cmd_valid;
    assign capture = (state_reg == WAIT) && (cnt_reg == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (bus.cmd_op != OP_ILLEGAL)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (op_reg == OP_WRITE) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Enables fall by default every cycle; addresses and data only move when their port is used.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_reg      <= '0;
            w_en_reg    <= 1'b0;
            r_en1_reg   <= 1'b0;
            r_en2_reg   <= 1'b0;
            w_adrs_reg  <= '0;
            r_adrs1_reg <= '0;
            r_adrs2_reg <= '0;
            data_in_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            w_en_reg  <= accept && (bus.cmd_op == OP_WRITE);
            r_en1_reg <= accept && bus.cmd_op[1];
            r_en2_reg <= accept && (bus.cmd_op == OP_READ2);
            if (accept) begin
                op_reg <= bus.cmd_op;
                if (bus.cmd_op == OP_WRITE) begin
                    w_adrs_reg  <= bus.cmd_adrs_a;
                    data_in_reg <= bus.cmd_wdata;
                end
                if (bus.cmd_op[1]) begin
                    r_adrs1_reg <= bus.cmd_adrs_a;
                end
                if (bus.cmd_op == OP_READ2) begin
                    r_adrs2_reg <= bus.cmd_adrs_b;
                end
                if (bus.cmd_op == OP_ILLEGAL) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_data1_reg <= '0;
            rsp_data2_reg <= '0;
        end else if (capture) begin
            rsp_data1_reg <= bus.data_out1;
            rsp_data2_reg <= (op_reg == OP_READ2) ? bus.data_out2 : '0;
        end
    end

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.rsp_valid   = (state_reg == RESP);
    assign bus.rsp_data1   = rsp_data1_reg;
    assign bus.rsp_data2   = rsp_data2_reg;
    assign bus.err_illegal = err_reg;
    assign bus.w_en        = w_en_reg;
    assign bus.w_adrs      = w_adrs_reg;
    assign bus.data_in     = data_in_reg;
    assign bus.r_en1       = r_en1_reg;
    assign bus.r_adrs1     = r_adrs1_reg;
    assign bus.r_en2       = r_en2_reg;
    assign bus.r_adrs2     = r_adrs2_reg;
endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: one instance with read latency 1, one with latency 3, each with its own memory model.
// Expected values come from a shadow copy of memory contents and cycle counts derived from the latency.
module tb_mem_initiator;
    localparam int AW = 11;
    localparam int DW = 11;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus, per instance
    logic          cmd_valid [2];
    logic [1:0]    cmd_op    [2];
    logic [AW-1:0] cmd_a     [2];
    logic [AW-1:0] cmd_b     [2];
    logic [DW-1:0] cmd_wd    [2];
    logic          rsp_ready [2];

    // observations, per instance
    logic          cmd_ready_o [2];
    logic          rsp_valid_o [2];
    logic          err_o       [2];
    logic          w_en_o      [2];
    logic          r_en1_o     [2];
    logic          r_en2_o     [2];
    logic [AW-1:0] w_adrs_o    [2];
    logic [AW-1:0] r_adrs1_o   [2];
    logic [AW-1:0] r_adrs2_o   [2];
    logic [DW-1:0] data_in_o   [2];
    logic [DW-1:0] rsp_d1_o    [2];
    logic [DW-1:0] rsp_d2_o    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;

        mem_initiator_if #(.AW(AW), .DW(DW)) bus ();

        mem_initiator #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus)
        );

        assign bus.cmd_valid  = cmd_valid[gi];
        assign bus.cmd_op     = cmd_op[gi];
        assign bus.cmd_adrs_a = cmd_a[gi];
        assign bus.cmd_adrs_b = cmd_b[gi];
        assign bus.cmd_wdata  = cmd_wd[gi];
        assign bus.rsp_ready  = rsp_ready[gi];

        assign cmd_ready_o[gi] = bus.cmd_ready;
        assign rsp_valid_o[gi] = bus.rsp_valid;
        assign err_o[gi]       = bus.err_illegal;
        assign w_en_o[gi]      = bus.w_en;
        assign r_en1_o[gi]     = bus.r_en1;
        assign r_en2_o[gi]     = bus.r_en2;
        assign w_adrs_o[gi]    = bus.w_adrs;
        assign r_adrs1_o[gi]   = bus.r_adrs1;
        assign r_adrs2_o[gi]   = bus.r_adrs2;
        assign data_in_o[gi]   = bus.data_in;
        assign rsp_d1_o[gi]    = bus.rsp_data1;
        assign rsp_d2_o[gi]    = bus.rsp_data2;

        // Memory: read data appears LAT cycles after the enable cycle, random junk otherwise.
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] p1 [LAT];
        logic [DW-1:0] p2 [LAT];
        logic          v1 [LAT];
        logic          v2 [LAT];
        logic [DW-1:0] junk1, junk2;

        initial begin
            for (int i = 0; i < 2**AW; i++) mem[i] = '0;
            for (int i = 0; i < LAT; i++) begin
                v1[i] = 1'b0;
                v2[i] = 1'b0;
                p1[i] = '0;
                p2[i] = '0;
            end
            junk1 = '0;
            junk2 = '0;
        end

        always @(posedge clk) begin
            if (bus.w_en) mem[bus.w_adrs] <= bus.data_in;
            p1[0] <= mem[bus.r_adrs1];
            p2[0] <= mem[bus.r_adrs2];
            v1[0] <= bus.r_en1;
            v2[0] <= bus.r_en2;
            for (int i = 1; i < LAT; i++) begin
                p1[i] <= p1[i-1];
                p2[i] <= p2[i-1];
                v1[i] <= v1[i-1];
                v2[i] <= v2[i-1];
            end
            junk1 <= DW'($urandom);
            junk2 <= DW'($urandom);
        end

        assign bus.data_out1 = v1[LAT-1] ? p1[LAT-1] : junk1;
        assign bus.data_out2 = v2[LAT-1] ? p2[LAT-1] : junk2;
    end

    // Reference: memory contents as the pipeline believes them, plus sticky error flag.
    logic [DW-1:0] ref_mem [2][2**AW];
    logic          ref_err [2];
    int            lat     [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        @(negedge clk);
        chk("wr_ready", k, cmd_ready_o[k], 1);
        cmd_valid[k] = 1'b1;
        cmd_op[k]    = 2'b01;
        cmd_a[k]     = a;
        cmd_b[k]     = AW'($urandom);
        cmd_wd[k]    = wd;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        chk("wr_c1_w_en", k, w_en_o[k], 1);
        chk("wr_c1_w_adrs", k, w_adrs_o[k], a);
        chk("wr_c1_data_in", k, data_in_o[k], wd);
        chk("wr_c1_r_en", k, {r_en1_o[k], r_en2_o[k]}, 0);
        chk("wr_c1_busy", k, cmd_ready_o[k], 0);
        @(negedge clk);
        chk("wr_c2_w_en", k, w_en_o[k], 0);
        chk("wr_c2_ready", k, cmd_ready_o[k], 1);
        chk("wr_c2_no_rsp", k, rsp_valid_o[k], 0);
        ref_mem[k][a] = wd;
        $display("dut%0d write adrs=%03h data=%03h", k, a, wd);
    endtask

    task automatic do_read(input int k, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input int hold);
        logic [DW-1:0] e1, e2;
        e1 = ref_mem[k][a];
        e2 = (op == 2'b11) ? ref_mem[k][b] : '0;
        @(negedge clk);
        chk("rd_ready", k, cmd_ready_o[k], 1);
        cmd_valid[k] = 1'b1;
        cmd_op[k]    = op;
        cmd_a[k]     = a;
        cmd_b[k]     = b;
        cmd_wd[k]    = DW'($urandom);
        rsp_ready[k] = (hold == 0);
        @(negedge clk);
        chk("rd_c1_r_en1", k, r_en1_o[k], 1);
        chk("rd_c1_r_en2", k, r_en2_o[k], (op == 2'b11));
        chk("rd_c1_w_en", k, w_en_o[k], 0);
        chk("rd_c1_r_adrs1", k, r_adrs1_o[k], a);
        if (op == 2'b11) chk("rd_c1_r_adrs2", k, r_adrs2_o[k], b);
        chk("rd_c1_busy", k, cmd_ready_o[k], 0);
        // an illegal command offered while busy must be ignored entirely
        cmd_op[k] = 2'b00;
        for (int i = 0; i < lat[k]; i++) begin
            @(negedge clk);
            chk("rd_wait_no_rsp", k, rsp_valid_o[k], 0);
            chk("rd_wait_r_en", k, {r_en1_o[k], r_en2_o[k]}, 0);
        end
        cmd_valid[k] = 1'b0;
        @(negedge clk);
        chk("rd_rsp_valid", k, rsp_valid_o[k], 1);
        chk("rd_rsp_data1", k, rsp_d1_o[k], e1);
        chk("rd_rsp_data2", k, rsp_d2_o[k], e2);
        chk("rd_rsp_busy", k, cmd_ready_o[k], 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rd_hold_valid", k, rsp_valid_o[k], 1);
            chk("rd_hold_data1", k, rsp_d1_o[k], e1);
            chk("rd_hold_data2", k, rsp_d2_o[k], e2);
            chk("rd_hold_busy", k, cmd_ready_o[k], 0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk("rd_done_valid", k, rsp_valid_o[k], 0);
        chk("rd_done_ready", k, cmd_ready_o[k], 1);
        chk("rd_err_unchanged", k, err_o[k], ref_err[k]);
        $display("dut%0d read op=%0d a=%03h b=%03h hold=%0d -> %03h/%03h", k, op, a, b, hold,
                 rsp_d1_o[k], rsp_d2_o[k]);
    endtask

    task automatic do_illegal(input int k);
        @(negedge clk);
        cmd_valid[k] = 1'b1;
        cmd_op[k]    = 2'b00;
        cmd_a[k]     = AW'($urandom);
        cmd_b[k]     = AW'($urandom);
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        ref_err[k]   = 1'b1;
        chk("ill_err", k, err_o[k], 1);
        chk("ill_ready", k, cmd_ready_o[k], 1);
        chk("ill_no_en", k, {w_en_o[k], r_en1_o[k], r_en2_o[k]}, 0);
        $display("dut%0d illegal op accepted err=%0b", k, err_o[k]);
    endtask

    task automatic chk_reset_state(input int k, input string tag);
        chk({tag, "_cmd_ready"}, k, cmd_ready_o[k], 1);
        chk({tag, "_rsp_valid"}, k, rsp_valid_o[k], 0);
        chk({tag, "_err"}, k, err_o[k], 0);
        chk({tag, "_en"}, k, {w_en_o[k], r_en1_o[k], r_en2_o[k]}, 0);
        chk({tag, "_adrs"}, k, {w_adrs_o[k], r_adrs1_o[k], r_adrs2_o[k]}, 0);
        chk({tag, "_data"}, k, {data_in_o[k], rsp_d1_o[k]}, 0);
        chk({tag, "_data2"}, k, rsp_d2_o[k], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] a, b;
        int            sel;

        lat[0] = 1;
        lat[1] = 3;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_op[k]    = 2'b00;
            cmd_a[k]     = '0;
            cmd_b[k]     = '0;
            cmd_wd[k]    = '0;
            rsp_ready[k] = 1'b0;
            ref_err[k]   = 1'b0;
            for (int i = 0; i < 2**AW; i++) ref_mem[k][i] = '0;
        end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) chk_reset_state(k, "rst");
        resetn = 1'b1;

        for (int k = 0; k < 2; k++) begin
            do_write(k, 11'h045, 11'h1A4);
            do_read(k, 2'b11, 11'h045, 11'h000, 0);
            do_read(k, 2'b10, 11'h045, 11'h000, 5);
            do_illegal(k);
            do_write(k, 11'h7FF, 11'h5C3);
            do_read(k, 2'b11, 11'h7FF, 11'h045, 1);

            for (int n = 0; n < 24; n++) begin
                sel = $urandom_range(0, 9);
                a   = AW'($urandom_range(0, 15));
                b   = AW'($urandom_range(0, 15));
                if (sel < 4) do_write(k, a, DW'($urandom));
                else if (sel < 6) do_read(k, 2'b10, a, b, $urandom_range(0, 3));
                else if (sel < 9) do_read(k, 2'b11, a, b, $urandom_range(0, 3));
                else do_illegal(k);
            end
        end

        // asynchronous reset in the middle of a latency-3 wait
        @(negedge clk);
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 2'b11;
        cmd_a[1]     = 11'h045;
        cmd_b[1]     = 11'h7FF;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            ref_err[k] = 1'b0;
            chk_reset_state(k, "async_rst");
        end
        $display("dut1 async reset during wait");
        @(negedge clk);
        chk("async_rst_hold_valid", 1, rsp_valid_o[1], 0);
        resetn    = 1'b1;
        rsp_ready[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 1, rsp_valid_o[1], 0);
        end
        do_read(1, 2'b11, 11'h045, 11'h7FF, 2);
        do_read(0, 2'b10, 11'h7FF, 11'h000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
